// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit between the CPU execute stage and a 4-bank
// (byte-lane) data memory with asynchronous read.
//
// One request is in flight at a time. Accepted requests are checked for a
// legal funct3, for falling inside the data-memory window and (in the default
// build) for natural alignment. Illegal requests answer in one cycle with
// rsp_err=1 and never touch memory. Legal ones take one word beat, or two
// when the access straddles a word boundary.
//
// Build option: define MISALIGN_EN to make misaligned accesses legal; the
// second beat state exists only in that build.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_funct3    store flag and RV32 size/sign code
//   req_addr, req_wdata   byte address, right-justified store data
//   rsp_valid/rsp_ready   response handshake (response held while stalled)
//   rsp_rdata, rsp_err    extended load data (0 for stores/errors), error flag
//   daddr, dwdata, dwe    word address, lane-shifted write data, lane enables
//   drdata                memory read data for daddr
module lsu_ctrl #(
   parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
   parameter int unsigned DMEM_BYTES = 16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] daddr,
   output logic [31:0] dwdata,
   output logic [3:0]  dwe,
   input  logic [31:0] drdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC0 = 2'd1,
`ifdef MISALIGN_EN
      S_ACC1 = 2'd2,
`endif
      S_RESP = 2'd3
   } state_t;

   state_t      state;
   logic        ready_q;
   logic [3:0]  dwe_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   // ---------------- request decode ----------------
   logic [1:0]  off;
   logic [2:0]  sz;
   logic [3:0]  ones;
   logic        legal_f3;
   logic        in_win;
   logic        req_err;
   logic [3:0]  beat0_dwe;
   logic [32:0] addr33, last33, win_lo, win_hi;

   assign off = req_addr[1:0];

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   begin sz = 3'd1; ones = 4'b0001; end
         2'b01:   begin sz = 3'd2; ones = 4'b0011; end
         default: begin sz = 3'd4; ones = 4'b1111; end
      endcase
   end

   always_comb begin
      if (req_we)
         legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
      else
         legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
   end

   // 33-bit window arithmetic so an access near 4 GiB cannot wrap back in
   assign addr33 = {1'b0, req_addr};
   assign last33 = addr33 + {30'd0, sz} - 33'd1;
   assign win_lo = {1'b0, DMEM_BASE};
   assign win_hi = win_lo + 33'(DMEM_BYTES) - 33'd1;
   assign in_win = (addr33 >= win_lo) && (last33 <= win_hi);

`ifdef MISALIGN_EN
   logic [7:0]  m8;
   logic        crossing;
   logic        cross_q;
   logic [3:0]  mhi_q;
   logic [31:0] wdata_q;
   logic [31:0] lo_q;

   assign m8        = {4'b0000, ones} << off;
   assign crossing  = ({1'b0, off} + sz) > 3'd4;
   assign req_err   = !legal_f3 || !in_win;
   assign beat0_dwe = req_we ? m8[3:0] : 4'b0000;
`else
   logic [3:0]  m4;
   logic        aligned;

   assign m4        = ones << off;
   assign aligned   = (off == 2'b00) || (sz == 3'd1) || ((sz == 3'd2) && !off[0]);
   assign req_err   = !legal_f3 || !in_win || !aligned;
   assign beat0_dwe = req_we ? m4 : 4'b0000;
`endif

   // ---------------- load data extraction ----------------
   // In the second beat the previous word is the low half of the pair.
   logic [63:0] rd_pair;
   logic [31:0] rd_al;
   logic [31:0] rd_ext;

   always_comb begin
      rd_pair = {32'h0, drdata};
`ifdef MISALIGN_EN
      if (state == S_ACC1)
         rd_pair = {drdata, lo_q};
`endif
   end

   assign rd_al = 32'(rd_pair >> {off_q, 3'b000});

   always_comb begin
      case (f3_q[1:0])
         2'b00:   rd_ext = f3_q[2] ? {24'h0, rd_al[7:0]}  : {{24{rd_al[7]}}, rd_al[7:0]};
         2'b01:   rd_ext = f3_q[2] ? {16'h0, rd_al[15:0]} : {{16{rd_al[15]}}, rd_al[15:0]};
         default: rd_ext = rd_al;
      endcase
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ready_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         daddr     <= '0;
         dwdata    <= '0;
         dwe_q     <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
`ifdef MISALIGN_EN
         cross_q   <= 1'b0;
         mhi_q     <= '0;
         wdata_q   <= '0;
         lo_q      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  off_q   <= off;
`ifdef MISALIGN_EN
                  cross_q <= crossing;
                  mhi_q   <= req_we ? m8[7:4] : 4'b0000;
                  wdata_q <= req_wdata;
`endif
                  if (req_err) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state  <= S_ACC0;
                     daddr  <= {req_addr[31:2], 2'b00};
                     dwe_q  <= beat0_dwe;
                     dwdata <= req_wdata << {off, 3'b000};
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_ACC0: begin
`ifdef MISALIGN_EN
               lo_q <= drdata;
               if (cross_q) begin
                  state  <= S_ACC1;
                  daddr  <= daddr + 32'd4;
                  dwe_q  <= mhi_q;
                  dwdata <= wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
               end else
`endif
               begin
                  state     <= S_RESP;
                  dwe_q     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= we_q ? '0 : rd_ext;
               end
            end
`ifdef MISALIGN_EN
            S_ACC1: begin
               state     <= S_RESP;
               dwe_q     <= '0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= we_q ? '0 : rd_ext;
            end
`endif
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  ready_q   <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = ready_q;
   // a store in flight is abandoned the moment reset rises
   assign dwe = reset ? 4'b0000 : dwe_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;
   localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
   localparam int unsigned DMEM_BYTES = 16384;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, daddr, dwdata, drdata;
   logic [3:0]  dwe;

   lsu_ctrl #(.DMEM_BASE(DMEM_BASE), .DMEM_BYTES(DMEM_BYTES)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
      .drdata(drdata)
   );

   always #5 clk = ~clk;

   // memory seen by the DUT (word banks) and the model's byte image
   logic [31:0] dmem [4096];
   logic [7:0]  refm [16384];
   assign drdata = dmem[daddr[13:2]];
   always @(posedge clk)
      for (int l = 0; l < 4; l++)
         if (dwe[l]) dmem[daddr[13:2]][8*l +: 8] <= dwdata[8*l +: 8];

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned cyc = 0;
   int unsigned acc_cyc = 0;
   int nrst = 0;
   bit active = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) nrst <= 0;
      else if (nrst < 3) nrst <= nrst + 1;
   end

   // model expectations for the request in flight
   logic        e_err;
   int unsigned e_nbeats;
   logic [31:0] e_daddr [2];
   logic [3:0]  e_dwe [2];
   logic [31:0] e_dwd [2];
   logic [31:0] e_rdata;
   logic        m_we;
   logic [31:0] m_addr, m_wd;
   int unsigned m_s;
   // beats observed on the memory port
   int unsigned bl_n;
   logic [31:0] bl_daddr [2];
   logic [3:0]  bl_dwe [2];
   logic [31:0] bl_dwd [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout expected handshake (t=%0t)", name, $time);
   endtask

   // What the unit must do, stated byte by byte.
   task automatic model_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
      int unsigned s, o, bt, lane;
      longint unsigned a, last, lo, hi;
      bit legal, ok_al;
      logic [31:0] v;
      s  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      o  = addr[1:0];
      legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      a    = addr;
      last = a + s - 1;
      lo   = DMEM_BASE;
      hi   = longint'(DMEM_BASE) + DMEM_BYTES - 1;
`ifdef MISALIGN_EN
      ok_al = 1'b1;
`else
      ok_al = (o % s) == 0;
`endif
      e_err    = !(legal && a >= lo && last <= hi && ok_al);
      e_nbeats = e_err ? 0 : ((o + s > 4) ? 2 : 1);
      e_daddr[0] = {addr[31:2], 2'b00};
      e_daddr[1] = e_daddr[0] + 32'd4;
      e_dwe[0] = '0; e_dwe[1] = '0;
      e_dwd[0] = '0; e_dwd[1] = '0;
      e_rdata  = '0;
      m_we = we; m_addr = addr; m_wd = wd; m_s = s;
      if (!e_err) begin
         v = '0;
         for (int unsigned j = 0; j < s; j++) begin
            bt   = ((addr + j) >> 2) - (addr >> 2);
            lane = (addr + j) & 3;
            if (we) begin
               e_dwe[bt][lane] = 1'b1;
               e_dwd[bt][8*lane +: 8] = wd[8*j +: 8];
            end else
               v[8*j +: 8] = refm[addr - DMEM_BASE + j];
         end
         if (!we) begin
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            e_rdata = v;
         end
      end
   endtask

   task automatic commit_store(input int unsigned nb);
      int unsigned bt;
      if (m_we && !e_err)
         for (int unsigned j = 0; j < m_s; j++) begin
            bt = ((m_addr + j) >> 2) - (m_addr >> 2);
            if (bt < nb) refm[m_addr - DMEM_BASE + j] = m_wd[8*j +: 8];
         end
   endtask

   // single compare process: every cycle against the model
   always @(negedge clk) begin : mon
      int unsigned k;
      logic [31:0] msk;
      if (reset) begin
         chk("dwe_in_reset", {28'h0, dwe}, 32'h0);
      end else if (active) begin
         k = cyc - acc_cyc;
         chk("req_ready_busy", req_ready, 1'b0);
         if (k >= 1 && k <= e_nbeats) begin
            chk("rsp_valid_early", rsp_valid, 1'b0);
            chk("beat_daddr", daddr, e_daddr[k-1]);
            chk("beat_dwe", dwe, e_dwe[k-1]);
            msk = {{8{e_dwe[k-1][3]}}, {8{e_dwe[k-1][2]}}, {8{e_dwe[k-1][1]}}, {8{e_dwe[k-1][0]}}};
            if (msk != 0) chk("beat_dwdata", dwdata & msk, e_dwd[k-1] & msk);
            bl_daddr[k-1] = daddr; bl_dwe[k-1] = dwe; bl_dwd[k-1] = dwdata; bl_n = k;
         end else begin
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_err", rsp_err, e_err);
            chk("dwe_in_resp", dwe, 4'b0000);
         end
      end else begin
         chk("rsp_valid_idle", rsp_valid, 1'b0);
         chk("dwe_idle", dwe, 4'b0000);
         if (nrst >= 1) chk("req_ready_idle", req_ready, 1'b1);
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall,
                         output logic [31:0] rd, output logic er, output int lat);
      int w;
      rd = '0; er = 1'b0; lat = 0; bl_n = 0;
      model_req(we, f3, addr, wd);
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      if (!req_ready) begin timeout_fail("req_ready_wait"); return; end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc_cyc = cyc - 1;
      active = 1'b1;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 8);
      if (!rsp_valid) begin timeout_fail("rsp_valid_wait"); active = 1'b0; return; end
      rd = rsp_rdata; er = rsp_err;
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      active = 1'b0;
      commit_store(e_nbeats);
   endtask

   // store abandoned by reset while beat 'beat' (1 or 2) is on the memory port
   task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wd,
                                  input int unsigned beat, input logic [3:0] pre_dwe);
      int w;
      bl_n = 0;
      model_req(1'b1, 3'b010, addr, wd);
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      if (!req_ready) begin timeout_fail("rst_req_ready_wait"); return; end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc_cyc = cyc - 1;
      active = 1'b1;
      repeat (beat - 1) begin @(posedge clk); #1; end
      chk("pre_reset_dwe", dwe, pre_dwe);
      active = 1'b0;
      reset = 1'b1;
      #1;
      chk("dwe_reset_gate", dwe, 4'b0000);
      @(posedge clk); #1;
      chk("rsp_valid_after_reset", rsp_valid, 1'b0);
      chk("req_ready_in_reset", req_ready, 1'b0);
      reset = 1'b0;
      commit_store(beat - 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no completion expected $finish (t=%0t)", $time);
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      logic [31:0] rd;
      logic er;
      int lat;
      logic [2:0] lf3 [5];
      logic [2:0] sf3 [3];
      lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      sf3 = '{3'b000, 3'b001, 3'b010};

      for (int i = 0; i < 4096; i++) dmem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      dmem[4] = 32'h8899_AABB;
      for (int i = 0; i < 16384; i++) refm[i] = dmem[i/4][8*(i%4) +: 8];

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // word load
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      chk("lw_0x10_data", rd, 32'h8899_AABB);
      chk("lw_0x10_err", er, 1'b0);
      chk("lw_0x10_latency", lat, 2);

      // byte store then signed/unsigned byte loads
      do_req(1'b1, 3'b000, 32'h13, 32'h80, 0, rd, er, lat);
      chk("sb_0x13_rdata", rd, 32'h0);
      do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er, lat);
      chk("lb_0x13_sext", rd, 32'hFFFF_FF80);
      do_req(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er, lat);
      chk("lbu_0x13_zext", rd, 32'h0000_0080);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      chk("lw_after_sb", rd, 32'h8099_AABB);

      // halfword store, one beat in the upper lanes
      do_req(1'b1, 3'b001, 32'h06, 32'h1234, 0, rd, er, lat);
      chk("sh_beats", bl_n, 1);
      chk("sh_daddr", bl_daddr[0], 32'h04);
      chk("sh_dwe", bl_dwe[0], 4'b1100);
      chk("sh_dwdata", bl_dwd[0], 32'h1234_0000);
      chk("sh_latency", lat, 2);
      do_req(1'b0, 3'b101, 32'h06, 32'h0, 0, rd, er, lat);
      chk("lhu_0x06", rd, 32'h0000_1234);
      do_req(1'b1, 3'b001, 32'h06, 32'hFFFF_8001, 0, rd, er, lat);
      do_req(1'b0, 3'b001, 32'h06, 32'h0, 0, rd, er, lat);
      chk("lh_0x06_sext", rd, 32'hFFFF_8001);

`ifdef MISALIGN_EN
      do_req(1'b1, 3'b010, 32'h0B, 32'hAABB_CCDD, 0, rd, er, lat);
      chk("sw_0x0b_beats", bl_n, 2);
      chk("sw_0x0b_b0_daddr", bl_daddr[0], 32'h08);
      chk("sw_0x0b_b0_dwe", bl_dwe[0], 4'b1000);
      chk("sw_0x0b_b0_byte", bl_dwd[0] >> 24, 32'hDD);
      chk("sw_0x0b_b1_daddr", bl_daddr[1], 32'h0C);
      chk("sw_0x0b_b1_dwe", bl_dwe[1], 4'b0111);
      chk("sw_0x0b_b1_bytes", bl_dwd[1] & 32'h00FF_FFFF, 32'h00AA_BBCC);
      chk("sw_0x0b_latency", lat, 3);
      do_req(1'b0, 3'b010, 32'h0B, 32'h0, 0, rd, er, lat);
      chk("lw_0x0b_data", rd, 32'hAABB_CCDD);
      chk("lw_0x0b_latency", lat, 3);
      do_req(1'b0, 3'b001, 32'h01, 32'h0, 0, rd, er, lat);
      chk("lh_0x01_err", er, 1'b0);
      chk("lh_0x01_latency", lat, 2);
`else
      do_req(1'b1, 3'b010, 32'h0B, 32'hAABB_CCDD, 0, rd, er, lat);
      chk("sw_0x0b_err", er, 1'b1);
      chk("sw_0x0b_latency", lat, 1);
      chk("sw_0x0b_no_beat", bl_n, 0);
      do_req(1'b0, 3'b001, 32'h01, 32'h0, 0, rd, er, lat);
      chk("lh_0x01_err", er, 1'b1);
      chk("lh_0x01_latency", lat, 1);
`endif

      // window edges and illegal codes
      do_req(1'b0, 3'b010, 32'h3FFE, 32'h0, 0, rd, er, lat);
      chk("lw_0x3ffe_err", er, 1'b1);
      chk("lw_0x3ffe_latency", lat, 1);
      chk("lw_0x3ffe_no_beat", bl_n, 0);
      do_req(1'b0, 3'b011, 32'h20, 32'h0, 0, rd, er, lat);
      chk("f3_011_err", er, 1'b1);
      do_req(1'b0, 3'b010, 32'h3FFC, 32'h0, 0, rd, er, lat);
      chk("lw_0x3ffc_ok", er, 1'b0);
      do_req(1'b0, 3'b100, 32'h4000, 32'h0, 0, rd, er, lat);
      chk("lbu_0x4000_err", er, 1'b1);
      do_req(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 0, rd, er, lat);
      chk("lb_top_err", er, 1'b1);
      do_req(1'b1, 3'b100, 32'h20, 32'h55, 0, rd, er, lat);
      chk("store_f3_100_err", er, 1'b1);

      // stalled response must hold still (checked each cycle by the monitor)
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er, lat);
      chk("lw_stalled_data", rd, 32'h8099_AABB);

      // every size at every offset
      for (int o = 0; o < 4; o++) begin
         for (int f = 0; f < 3; f++)
            do_req(1'b1, sf3[f], 32'h80 + 32'(o) + 32'(16*f), 32'hC3A5_7E19 + 32'(o*f), 0, rd, er, lat);
         for (int f = 0; f < 5; f++)
            do_req(1'b0, lf3[f], 32'h80 + 32'(o) + 32'(16*(f % 3)), 32'h0, 0, rd, er, lat);
      end

      // reset while a store is on the memory port
`ifdef MISALIGN_EN
      reset_mid_store(32'h0D, 32'hDEAD_BEEF, 2, 4'b0001);
      do_req(1'b0, 3'b010, 32'h0C, 32'h0, 0, rd, er, lat);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      chk("word_0x10_untouched", rd, 32'h8099_AABB);
`else
      reset_mid_store(32'h20, 32'hDEAD_BEEF, 1, 4'b1111);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat);
      chk("word_0x20_untouched", rd, (32'd8 * 32'h9E37_79B9) ^ 32'h5A5A_0F0F);
`endif

      for (int w = 0; w < 48; w++)
         chk("mem_word", dmem[w], {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]});
      chk("mem_word_top", dmem[4095], {refm[16383], refm[16382], refm[16381], refm[16380]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
